// File: rtl/v_regfile.sv
// Vector register file: 32 x VREG_DW storage, one write port, two combinational
// read ports and a pending-write scoreboard. Optional forwarding: VREGFILE_BYPASS_EN.
module v_regfile #(
   parameter int VREG_DW = 512,
   parameter int VREG_AW = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vwb_en_i,
   input  logic [VREG_AW-1:0] vwb_addr_i,
   input  logic [VREG_DW-1:0] vwb_data_i,
   input  logic               vrs1_en_i,
   input  logic [VREG_AW-1:0] vrs1_addr_i,
   output logic [VREG_DW-1:0] vrs1_data_o,
   output logic               vrs1_busy_o,
   input  logic               vrs2_en_i,
   input  logic [VREG_AW-1:0] vrs2_addr_i,
   output logic [VREG_DW-1:0] vrs2_data_o,
   output logic               vrs2_busy_o,
   input  logic               vissue_en_i,
   input  logic [VREG_AW-1:0] vissue_addr_i,
   output logic               vrd_busy_o
);

   localparam int VREG_NUM = 2 ** VREG_AW;

   logic [VREG_DW-1:0]  mem [VREG_NUM];
   logic [VREG_NUM-1:0] busy;

   // Issue is applied after write-back so a new producer wins over a retiring one.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < VREG_NUM; i++) begin
            mem[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (vwb_en_i) begin
            mem[vwb_addr_i]  <= vwb_data_i;
            busy[vwb_addr_i] <= 1'b0;
         end
         if (vissue_en_i) begin
            busy[vissue_addr_i] <= 1'b1;
         end
      end
   end

   logic [VREG_DW-1:0] rd1_raw;
   logic [VREG_DW-1:0] rd2_raw;
   logic               bz1_raw;
   logic               bz2_raw;
   logic               bzd_raw;

`ifdef VREGFILE_BYPASS_EN
   logic fwd1;
   logic fwd2;
   logic fwdd;

   assign fwd1    = vwb_en_i && (vwb_addr_i == vrs1_addr_i);
   assign fwd2    = vwb_en_i && (vwb_addr_i == vrs2_addr_i);
   assign fwdd    = vwb_en_i && (vwb_addr_i == vissue_addr_i);
   assign rd1_raw = fwd1 ? vwb_data_i : mem[vrs1_addr_i];
   assign rd2_raw = fwd2 ? vwb_data_i : mem[vrs2_addr_i];
   assign bz1_raw = busy[vrs1_addr_i] & ~fwd1;
   assign bz2_raw = busy[vrs2_addr_i] & ~fwd2;
   assign bzd_raw = busy[vissue_addr_i] & ~fwdd;
`else
   assign rd1_raw = mem[vrs1_addr_i];
   assign rd2_raw = mem[vrs2_addr_i];
   assign bz1_raw = busy[vrs1_addr_i];
   assign bz2_raw = busy[vrs2_addr_i];
   assign bzd_raw = busy[vissue_addr_i];
`endif

   // Reset forces every output low regardless of the enables.
   assign vrs1_data_o = (!rst && vrs1_en_i) ? rd1_raw : '0;
   assign vrs2_data_o = (!rst && vrs2_en_i) ? rd2_raw : '0;
   assign vrs1_busy_o = !rst && vrs1_en_i && bz1_raw;
   assign vrs2_busy_o = !rst && vrs2_en_i && bz2_raw;
   assign vrd_busy_o  = !rst && vissue_en_i && bzd_raw;

endmodule

// File: tb/tb_v_regfile.sv
// Self-checking bench for v_regfile: directed scenarios plus randomized traffic
// against an array-based reference model. Honours VREGFILE_BYPASS_EN.
module tb_v_regfile;

   localparam int DW = 512;
   localparam int AW = 5;
`ifdef VREGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          vwb_en;
   logic [AW-1:0] vwb_addr;
   logic [DW-1:0] vwb_data;
   logic          vrs1_en;
   logic [AW-1:0] vrs1_addr;
   logic [DW-1:0] vrs1_data;
   logic          vrs1_busy;
   logic          vrs2_en;
   logic [AW-1:0] vrs2_addr;
   logic [DW-1:0] vrs2_data;
   logic          vrs2_busy;
   logic          vissue_en;
   logic [AW-1:0] vissue_addr;
   logic          vrd_busy;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ref_mem  [32];
   bit            ref_busy [32];

   v_regfile #(.VREG_DW(DW), .VREG_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .vwb_en_i(vwb_en), .vwb_addr_i(vwb_addr), .vwb_data_i(vwb_data),
      .vrs1_en_i(vrs1_en), .vrs1_addr_i(vrs1_addr), .vrs1_data_o(vrs1_data), .vrs1_busy_o(vrs1_busy),
      .vrs2_en_i(vrs2_en), .vrs2_addr_i(vrs2_addr), .vrs2_data_o(vrs2_data), .vrs2_busy_o(vrs2_busy),
      .vissue_en_i(vissue_en), .vissue_addr_i(vissue_addr), .vrd_busy_o(vrd_busy)
   );

   always #5 clk = ~clk;

   // Reference model: reset clears, write-back stores and retires, issue marks pending last.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            ref_mem[i]  = '0;
            ref_busy[i] = 1'b0;
         end
      end else begin
         if (vwb_en) begin
            ref_mem[vwb_addr]  = vwb_data;
            ref_busy[vwb_addr] = 1'b0;
         end
         if (vissue_en) ref_busy[vissue_addr] = 1'b1;
      end
   end

   function automatic logic [DW-1:0] exp_data(input logic en, input logic [AW-1:0] a);
      if (rst || !en) return '0;
      if (BYP && vwb_en && vwb_addr == a) return vwb_data;
      return ref_mem[a];
   endfunction

   function automatic logic exp_busy(input logic en, input logic [AW-1:0] a);
      if (rst || !en) return 1'b0;
      if (BYP && vwb_en && vwb_addr == a) return 1'b0;
      return ref_busy[a];
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle();
      vwb_en = 0; vwb_addr = '0; vwb_data = '0;
      vrs1_en = 0; vrs1_addr = '0;
      vrs2_en = 0; vrs2_addr = '0;
      vissue_en = 0; vissue_addr = '0;
   endtask

   // Advance one rising edge; inputs are then redriven after the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [DW-1:0] aa;
      aa = {64{8'hAA}};
      rst = 1; idle();
      @(negedge clk); tick(); tick();
      rst = 0;
      vrs1_en = 1; vrs1_addr = 5'd0; vrs2_en = 1; vrs2_addr = 5'd31;
      vissue_en = 1; vissue_addr = 5'd0;
      #1;
      checks++; if (vrs1_data !== '0 || vrs2_data !== '0) begin errors++; $display("[TB] FAIL reset_data got %h / %h exp 0", vrs1_data, vrs2_data); end
      checks++; if ({vrs1_busy, vrs2_busy, vrd_busy} !== 3'b000) begin errors++; $display("[TB] FAIL reset_busy got %b exp 000", {vrs1_busy, vrs2_busy, vrd_busy}); end
      idle();
      vwb_en = 1; vwb_addr = 5'd3; vwb_data = aa;
      tick();
      idle(); rst = 1;
      vrs1_en = 1; vrs1_addr = 5'd3; vrs2_en = 1; vrs2_addr = 5'd3;
      vissue_en = 1; vissue_addr = 5'd3;
      #1;
      checks++; if (vrs1_data !== '0 || vrs2_data !== '0) begin errors++; $display("[TB] FAIL rst_forces_zero got %h exp 0", vrs1_data); end
      tick();
      rst = 0;
      #1;
      checks++; if (vrs1_data !== '0 || vrs2_data !== '0) begin errors++; $display("[TB] FAIL v3_cleared got %h / %h exp 0", vrs1_data, vrs2_data); end
      checks++; if ({vrs1_busy, vrs2_busy, vrd_busy} !== 3'b000) begin errors++; $display("[TB] FAIL rst_blocks_issue got %b exp 000", {vrs1_busy, vrs2_busy, vrd_busy}); end
      idle(); rst = 1;
      vwb_en = 1; vwb_addr = 5'd4; vwb_data = 512'h5;
      tick();
      idle(); rst = 0;
      vrs1_en = 1; vrs1_addr = 5'd4;
      #1;
      checks++; if (vrs1_data !== '0) begin errors++; $display("[TB] FAIL rst_blocks_write got %h exp 0", vrs1_data); end
   endtask

   task automatic test_basic();
      idle();
      vwb_en = 1; vwb_addr = 5'd5; vwb_data = 512'h1234;
      tick();
      idle();
      vrs1_en = 1; vrs1_addr = 5'd5; vrs2_en = 1; vrs2_addr = 5'd6;
      #1;
      checks++; if (vrs1_data !== 512'h1234) begin errors++; $display("[TB] FAIL basic_rd1 got %h exp %h", vrs1_data, 512'h1234); end
      checks++; if (vrs2_data !== '0) begin errors++; $display("[TB] FAIL basic_rd2 got %h exp 0", vrs2_data); end
      vrs1_en = 0;
      #1;
      checks++; if (vrs1_data !== '0) begin errors++; $display("[TB] FAIL rd1_disabled got %h exp 0", vrs1_data); end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] e;
      idle();
      vwb_en = 1; vwb_addr = 5'd7; vwb_data = 512'h11;
      tick();
      idle();
      vwb_en = 1; vwb_addr = 5'd7; vwb_data = 512'h22;
      vrs1_en = 1; vrs1_addr = 5'd7;
      #1;
      e = BYP ? 512'h22 : 512'h11;
      checks++; if (vrs1_data !== e) begin errors++; $display("[TB] FAIL bypass_same_cycle got %h exp %h", vrs1_data, e); end
      tick();
      idle();
      vrs1_en = 1; vrs1_addr = 5'd7;
      #1;
      checks++; if (vrs1_data !== 512'h22) begin errors++; $display("[TB] FAIL bypass_next_cycle got %h exp %h", vrs1_data, 512'h22); end
   endtask

   task automatic test_scoreboard();
      logic [DW-1:0] e;
      idle();
      vissue_en = 1; vissue_addr = 5'd9; vrs2_en = 1; vrs2_addr = 5'd9;
      #1;
      checks++; if (vrs2_busy !== 1'b0) begin errors++; $display("[TB] FAIL sb_issue_cycle got %b exp 0", vrs2_busy); end
      tick();
      idle(); vrs2_en = 1; vrs2_addr = 5'd9;
      #1;
      checks++; if (vrs2_busy !== 1'b1) begin errors++; $display("[TB] FAIL sb_busy_t1 got %b exp 1", vrs2_busy); end
      tick();
      vissue_en = 1; vissue_addr = 5'd9;
      #1;
      checks++; if (vrd_busy !== 1'b1) begin errors++; $display("[TB] FAIL sb_waw got %b exp 1", vrd_busy); end
      tick();
      idle();
      vwb_en = 1; vwb_addr = 5'd9; vwb_data = 512'h99;
      vrs2_en = 1; vrs2_addr = 5'd9;
      #1;
      checks++; if (vrs2_busy !== !BYP) begin errors++; $display("[TB] FAIL sb_wb_cycle got %b exp %b", vrs2_busy, !BYP); end
      e = BYP ? 512'h99 : 512'h0;
      checks++; if (vrs2_data !== e) begin errors++; $display("[TB] FAIL sb_wb_data got %h exp %h", vrs2_data, e); end
      tick();
      idle(); vrs2_en = 1; vrs2_addr = 5'd9;
      #1;
      checks++; if (vrs2_busy !== 1'b0 || vrs2_data !== 512'h99) begin errors++; $display("[TB] FAIL sb_retired got %b/%h exp 0/%h", vrs2_busy, vrs2_data, 512'h99); end
   endtask

   task automatic test_set_clear();
      idle();
      vissue_en = 1; vissue_addr = 5'd10;
      tick();
      idle();
      vissue_en = 1; vissue_addr = 5'd10;
      vwb_en = 1; vwb_addr = 5'd10; vwb_data = 512'hAB;
      #1;
      checks++; if (vrd_busy !== !BYP) begin errors++; $display("[TB] FAIL setclr_vrd got %b exp %b", vrd_busy, !BYP); end
      tick();
      idle(); vrs1_en = 1; vrs1_addr = 5'd10;
      #1;
      checks++; if (vrs1_busy !== 1'b1) begin errors++; $display("[TB] FAIL setclr_busy got %b exp 1", vrs1_busy); end
      checks++; if (vrs1_data !== 512'hAB) begin errors++; $display("[TB] FAIL setclr_data got %h exp %h", vrs1_data, 512'hAB); end
   endtask

   task automatic test_dual_port();
      logic [DW-1:0] ones;
      ones = '1;
      idle();
      vwb_en = 1; vwb_addr = 5'd31; vwb_data = ones;
      tick();
      idle();
      vrs1_en = 1; vrs1_addr = 5'd31; vrs2_en = 1; vrs2_addr = 5'd31;
      #1;
      checks++; if (vrs1_data !== ones || vrs2_data !== ones) begin errors++; $display("[TB] FAIL dual_data got %h / %h exp all ones", vrs1_data, vrs2_data); end
      checks++; if (vrs1_busy !== 1'b0 || vrs2_busy !== 1'b0) begin errors++; $display("[TB] FAIL dual_busy got %b%b exp 00", vrs1_busy, vrs2_busy); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst         = ($urandom_range(0, 39) == 0);
         vwb_en      = $urandom_range(0, 1);
         vwb_addr    = 5'($urandom_range(0, 7));
         vwb_data    = rand_data();
         vrs1_en     = ($urandom_range(0, 3) != 0);
         vrs1_addr   = 5'($urandom_range(0, 7));
         vrs2_en     = ($urandom_range(0, 3) != 0);
         vrs2_addr   = ($urandom_range(0, 1) != 0) ? vrs1_addr : 5'($urandom);
         vissue_en   = $urandom_range(0, 1);
         vissue_addr = 5'($urandom_range(0, 7));
         #1;
         checks++; if (vrs1_data !== exp_data(vrs1_en, vrs1_addr)) begin errors++; $display("[TB] FAIL rnd_rd1 n=%0d got %h exp %h", n, vrs1_data, exp_data(vrs1_en, vrs1_addr)); end
         checks++; if (vrs2_data !== exp_data(vrs2_en, vrs2_addr)) begin errors++; $display("[TB] FAIL rnd_rd2 n=%0d got %h exp %h", n, vrs2_data, exp_data(vrs2_en, vrs2_addr)); end
         checks++; if (vrs1_busy !== exp_busy(vrs1_en, vrs1_addr)) begin errors++; $display("[TB] FAIL rnd_bz1 n=%0d got %b exp %b", n, vrs1_busy, exp_busy(vrs1_en, vrs1_addr)); end
         checks++; if (vrs2_busy !== exp_busy(vrs2_en, vrs2_addr)) begin errors++; $display("[TB] FAIL rnd_bz2 n=%0d got %b exp %b", n, vrs2_busy, exp_busy(vrs2_en, vrs2_addr)); end
         checks++; if (vrd_busy !== exp_busy(vissue_en, vissue_addr)) begin errors++; $display("[TB] FAIL rnd_vrd n=%0d got %b exp %b", n, vrd_busy, exp_busy(vissue_en, vissue_addr)); end
         tick();
      end
      rst = 0;
      idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bypass();
      test_scoreboard();
      test_set_clear();
      test_dual_port();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/v_regfile.md
Name: v_regfile

Overview:
Vector register file at the receiving end of the vector write-back port. It takes the single write (enable/address/data) driven by the write-back stage and serves two combinational read ports to vector decode/issue. It also keeps a per-register pending-write scoreboard, so issue can stall on read-after-write hazards. Sits between v_write_back (write side) and vector decode/execute (read side).

Parameters:
VREG_DW  512  width of one vector register in bits
VREG_AW  5  register address width; entry count VREG_NUM = 2**VREG_AW (32)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
vwb_en_i  input  1  write enable from write-back
vwb_addr_i  input  VREG_AW  write destination register
vwb_data_i  input  VREG_DW  write data
vrs1_en_i  input  1  read port 1 enable
vrs1_addr_i  input  VREG_AW  read port 1 address
vrs1_data_o  output  VREG_DW  read port 1 data
vrs1_busy_o  output  1  read port 1 register has a pending write
vrs2_en_i  input  1  read port 2 enable
vrs2_addr_i  input  VREG_AW  read port 2 address
vrs2_data_o  output  VREG_DW  read port 2 data
vrs2_busy_o  output  1  read port 2 register has a pending write
vissue_en_i  input  1  an instruction writing a vector register issues this cycle
vissue_addr_i  input  VREG_AW  destination of issuing instruction
vrd_busy_o  output  1  vissue_addr_i register already has a pending write (WAW)

Behaviour:
- Storage: VREG_NUM x VREG_DW flops mem[]; busy[] vector of VREG_NUM bits. All registers, v0 included, are writable; none is hardwired.
- Reset (synchronous, clk edge with rst=1): every mem entry = 0; every busy bit = 0. rst overrides a same-cycle write or issue; neither takes effect.
- While rst=1, all outputs = 0 combinationally: data_o, busy_o, vrd_busy_o.
- Write: at posedge, if vwb_en_i=1 then mem[vwb_addr_i] <= vwb_data_i. New value is visible on reads from the next cycle (latency 1). Write with vwb_en_i=0 changes nothing.
- Read (combinational, 0 latency):
  - vrsN_data_o = mem[vrsN_addr_i] when vrsN_en_i=1, else 0.
  - Both ports may read the same address in the same cycle; both return identical data.
- Scoreboard update at posedge, priority order:
  1. busy[vwb_addr_i] <= 0 if vwb_en_i.
  2. busy[vissue_addr_i] <= 1 if vissue_en_i.
  - Issue and write-back to the same address in the same cycle: set wins (busy=1). This covers a new producer issuing as the old one retires.
  - Write-back to a non-busy register is legal and leaves it 0.
- Busy outputs (combinational):
  - vrsN_busy_o = vrsN_en_i & busy[vrsN_addr_i].
  - vrd_busy_o = vissue_en_i & busy[vissue_addr_i].
  - Issue logic is responsible for stalling; this block never blocks a write or issue.
- Address range: VREG_AW bits cover all entries exactly; no out-of-range case exists.

Optional Feature:
VREGFILE_BYPASS_EN
- Defined: write-to-read forwarding in the write cycle.
  - If vwb_en_i=1 and vrsN_en_i=1 and vwb_addr_i==vrsN_addr_i, then vrsN_data_o = vwb_data_i and vrsN_busy_o = 0.
  - vrd_busy_o likewise reads 0 when vwb_addr_i==vissue_addr_i with vwb_en_i=1.
  - Read-after-write latency becomes 0.
- Undefined: no forwarding.
  - Reads return the old mem value and the old busy bit during the write cycle.
  - Read-after-write latency is 1 cycle.

Test Plan:
- Reset: write v3=0xAA..AA, assert rst one cycle, then read v3 on both ports -> data 0, busy 0; rst asserted alongside vwb_en_i to v4 -> v4 stays 0.
- Basic write/read: write v5=0x1234 (zero-extended) at cycle t -> vrs1 read of v5 at t+1 returns 0x1234. vrs2 read of v6 at t+1 returns 0. vrs1_en_i=0 -> data 0.
- Bypass: v7=0x11 stored; in cycle t write v7=0x22 while vrs1 reads v7.
  - With VREGFILE_BYPASS_EN: 0x22 at t.
  - Without: 0x11 at t, 0x22 at t+1.
- Scoreboard: issue v9 at t -> vrs2_busy_o=1 for v9 from t+1. Write-back v9 at t+3 -> busy=0 from t+4 (from t+3 with bypass). Re-issue v9 while busy -> vrd_busy_o=1.
- Simultaneous set/clear: v10 busy; same cycle issue v10 and write-back v10 -> v10 busy=1 next cycle, mem[v10] updated.
- Dual-port same address: write v31=all-ones, then read v31 on both ports same cycle -> both all-ones, both busy 0.
